regmap_arbiter: RTL and testbench
=================================

// Module: regmap_arbiter
// PURPOSE
//  Two-requester round-robin arbiter/sequencer in front of the register-map
//  slave port (WRITE/READ/ADDR/WRITE_DATA/READ_DATA). Serialises accesses,
//  range-checks addresses, returns read data with a one-cycle ACK per access.
// PARAMETERS
//  AW        3   address width (requester and slave side)
//  DW        2   data width
//  NUM_REGS  2   valid addresses 0..NUM_REGS-1; others are rejected with ERR
//  CW        8   statistics counter width (REGMAP_ARB_STATS_EN only)
// PORTS
//  CLK         in   1   clock, rising edge
//  RST         in   1   reset: synchronous, active-high
//  REQ0/REQ1   in   1   request from requester 0/1; held until its ACK
//  WE0/WE1     in   1   1 = write, 0 = read; stable while REQn high
//  ADDR0/ADDR1 in   AW  access address; stable while REQn high
//  WDATA0/1    in   DW  write data; stable while REQn high
//  ACK0/ACK1   out  1   one-cycle completion pulse
//  RDATA0/1    out  DW  read data, valid only in the ACKn cycle (0 on writes)
//  ERR0/ERR1   out  1   out-of-range flag, valid only in the ACKn cycle
//  WRITE       out  1   slave write strobe
//  READ        out  1   slave read strobe
//  ADDR        out  AW  slave address
//  WRITE_DATA  out  DW  slave write data
//  READ_DATA   in   DW  slave read data, combinational from ADDR
// BEHAVIOUR
//  - All outputs registered. Reset: state IDLE, ACKn/ERRn/RDATAn=0, WRITE=
//    READ=0, ADDR=0, WRITE_DATA=0, last-served pointer=1 (requester 0 wins tie).
//  - FSM: IDLE -> ISSUE -> RESP -> IDLE.
//    IDLE: if any REQn, pick winner, latch WE/ADDR/WDATA, go ISSUE; else stay.
//    ISSUE: if ADDR<NUM_REGS drive WRITE (WE=1) or READ (WE=0) high for exactly
//      this cycle with latched ADDR/WRITE_DATA; capture READ_DATA at cycle end.
//      If ADDR>=NUM_REGS: no strobe, set error flag. Go RESP.
//    RESP: ACKn=1 for winner only, RDATAn/ERRn valid; update pointer; go IDLE.
//  - Latency: REQ sampled high at edge k -> strobe cycle k+1 -> ACK cycle k+2.
//    Throughput: one access per 3 cycles; REQ still high in cycle after ACK
//    is a new transaction.
//  - Round-robin: only one requesting -> it wins; both -> the one not last
//    served wins. Loser keeps REQ high and is served next.
//  - WRITE and READ never high together; ACK0 and ACK1 never high together.
//  - REQn dropping before ACK is a protocol violation; latched copy completes.
//  - RST mid-transaction: access aborted, no ACK, strobes low the next cycle.
// CONFIGURATION
//  - REGMAP_ARB_STATS_EN defined: adds outputs STAT_CNT0/STAT_CNT1 [CW-1:0],
//    incremented on each ACKn (incl. ERR), saturate at all-ones, cleared by RST.
//  - Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  - Package regmap_arb_pkg: FSM state enum (IDLE/ISSUE/RESP), default AW/DW/
//    NUM_REGS/CW constants.
//  - One sub-module regmap_rr_pick: 2-way round-robin pick from (req[1:0],
//    last) -> grant index; combinational.
// TESTING
//  1 Write: REQ0,WE0=1,ADDR0=0,WDATA0=2'b10 -> WRITE=1 ADDR=0 WRITE_DATA=2 at
//    k+1, ACK0 at k+2, ERR0=0; later read of addr 0 -> RDATA0=2'b10.
//  2 Read: REQ1,WE1=0,ADDR1=1 with slave READ_DATA=2'b01 -> READ=1 at k+1,
//    ACK1 with RDATA1=2'b01 at k+2.
//  3 Contention from reset: REQ0/REQ1 both held -> grant order 0,1,0,1; ACKs
//    3 cycles apart; never both ACKs or both strobes high.
//  4 Out of range: REQ0 ADDR0=5 -> no WRITE/READ, ACK0=1 ERR0=1 RDATA0=0.
//  5 RST asserted in ISSUE cycle -> no ACK, all outputs 0 next cycle, next
//    tie goes to requester 0.
//  6 STATS_EN: 300 ACKs on requester 0 with CW=8 -> STAT_CNT0=255, CNT1=0.

Source files
------------

// File: rtl/regmap_arb_pkg.sv
// Shared types and default sizing for the two-requester register-map arbiter.
package regmap_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_e;

  localparam int AW_DEF       = 3;
  localparam int DW_DEF       = 2;
  localparam int NUM_REGS_DEF = 2;
  localparam int CW_DEF       = 8;

endpackage

// File: rtl/regmap_rr_pick.sv
// Two-way round-robin pick: returns the index of the requester to serve.
module regmap_rr_pick (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       gnt_o
);

  // On a tie the requester that was not served last wins.
  always_comb begin
    gnt_o = 1'b0;
    if (req_i == 2'b11) begin
      gnt_o = ~last_i;
    end else if (req_i[1]) begin
      gnt_o = 1'b1;
    end else begin
      gnt_o = 1'b0;
    end
  end

endmodule

// File: rtl/regmap_arbiter.sv
// Round-robin sequencer serialising two requesters onto the register-map slave port.
// Optional REGMAP_ARB_STATS_EN adds saturating per-requester ACK counters.
module regmap_arbiter
  import regmap_arb_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF
`ifdef REGMAP_ARB_STATS_EN
  ,
  parameter int CW       = CW_DEF
`endif
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          REQ0,
  input  logic          REQ1,
  input  logic          WE0,
  input  logic          WE1,
  input  logic [AW-1:0] ADDR0,
  input  logic [AW-1:0] ADDR1,
  input  logic [DW-1:0] WDATA0,
  input  logic [DW-1:0] WDATA1,
  output logic          ACK0,
  output logic          ACK1,
  output logic [DW-1:0] RDATA0,
  output logic [DW-1:0] RDATA1,
  output logic          ERR0,
  output logic          ERR1,
  output logic          WRITE,
  output logic          READ,
  output logic [AW-1:0] ADDR,
  output logic [DW-1:0] WRITE_DATA,
  input  logic [DW-1:0] READ_DATA
`ifdef REGMAP_ARB_STATS_EN
  ,
  output logic [CW-1:0] STAT_CNT0,
  output logic [CW-1:0] STAT_CNT1
`endif
);

  localparam logic [AW:0] NUM_REGS_W = NUM_REGS[AW:0];

  arb_state_e    state_q, state_d;
  logic          last_q, last_d;
  logic          win_q, win_d;
  logic          we_q, we_d;
  logic          inr_q, inr_d;
  logic          write_q, write_d, read_q, read_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          ack0_q, ack0_d, ack1_q, ack1_d;
  logic          err0_q, err0_d, err1_q, err1_d;
  logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic          gnt_s;

  regmap_rr_pick u_pick (
    .req_i  ({REQ1, REQ0}),
    .last_i (last_q),
    .gnt_o  (gnt_s)
  );

  // Next-state and registered-output computation for the IDLE/ISSUE/RESP sequence.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    win_d    = win_q;
    we_d     = we_q;
    inr_d    = inr_q;
    write_d  = 1'b0;
    read_d   = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    err0_d   = 1'b0;
    err1_d   = 1'b0;
    rdata0_d = {DW{1'b0}};
    rdata1_d = {DW{1'b0}};
    case (state_q)
      IDLE: begin
        if (REQ0 || REQ1) begin
          win_d   = gnt_s;
          we_d    = gnt_s ? WE1 : WE0;
          addr_d  = gnt_s ? ADDR1 : ADDR0;
          wdata_d = gnt_s ? WDATA1 : WDATA0;
          inr_d   = ({1'b0, addr_d} < NUM_REGS_W);
          // Strobes are registered here so they are high during the ISSUE cycle.
          write_d = inr_d & we_d;
          read_d  = inr_d & ~we_d;
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        ack0_d = ~win_q;
        ack1_d = win_q;
        if (win_q) begin
          err1_d   = ~inr_q;
          rdata1_d = (inr_q && !we_q) ? READ_DATA : {DW{1'b0}};
        end else begin
          err0_d   = ~inr_q;
          rdata0_d = (inr_q && !we_q) ? READ_DATA : {DW{1'b0}};
        end
        state_d = RESP;
      end
      RESP: begin
        last_d  = win_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      win_q    <= 1'b0;
      we_q     <= 1'b0;
      inr_q    <= 1'b0;
      write_q  <= 1'b0;
      read_q   <= 1'b0;
      addr_q   <= {AW{1'b0}};
      wdata_q  <= {DW{1'b0}};
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      rdata0_q <= {DW{1'b0}};
      rdata1_q <= {DW{1'b0}};
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      win_q    <= win_d;
      we_q     <= we_d;
      inr_q    <= inr_d;
      write_q  <= write_d;
      read_q   <= read_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      err0_q   <= err0_d;
      err1_q   <= err1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign ACK0       = ack0_q;
  assign ACK1       = ack1_q;
  assign RDATA0     = rdata0_q;
  assign RDATA1     = rdata1_q;
  assign ERR0       = err0_q;
  assign ERR1       = err1_q;
  assign WRITE      = write_q;
  assign READ       = read_q;
  assign ADDR       = addr_q;
  assign WRITE_DATA = wdata_q;

`ifdef REGMAP_ARB_STATS_EN
  logic [CW-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  // Saturating counters advance together with the registered ACK pulse.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (ack0_d && (cnt0_q != {CW{1'b1}})) begin
      cnt0_d = cnt0_q + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt0_d = cnt0_q;
    end
    if (ack1_d && (cnt1_q != {CW{1'b1}})) begin
      cnt1_d = cnt1_q + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt1_d = cnt1_q;
    end
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt0_q <= {CW{1'b0}};
      cnt1_q <= {CW{1'b0}};
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign STAT_CNT0 = cnt0_q;
  assign STAT_CNT1 = cnt1_q;
`endif

endmodule

// File: tb/tb_regmap_arbiter.sv
// Scoreboard bench for regmap_arbiter: expected strobes/ACKs are queued by the stimulus
// and consumed by a negedge monitor.
module tb_regmap_arbiter;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       REQ0 = 1'b0, REQ1 = 1'b0, WE0 = 1'b0, WE1 = 1'b0;
  logic [2:0] ADDR0 = 3'd0, ADDR1 = 3'd0;
  logic [1:0] WDATA0 = 2'd0, WDATA1 = 2'd0;
  logic       ACK0, ACK1, ERR0, ERR1, WRITE, READ;
  logic [1:0] RDATA0, RDATA1, WRITE_DATA, READ_DATA;
  logic [2:0] ADDR;
`ifdef REGMAP_ARB_STATS_EN
  logic [7:0] STAT_CNT0, STAT_CNT1;
`endif

  regmap_arbiter dut (
    .CLK(CLK), .RST(RST),
    .REQ0(REQ0), .REQ1(REQ1), .WE0(WE0), .WE1(WE1),
    .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
    .ACK0(ACK0), .ACK1(ACK1), .RDATA0(RDATA0), .RDATA1(RDATA1),
    .ERR0(ERR0), .ERR1(ERR1), .WRITE(WRITE), .READ(READ),
    .ADDR(ADDR), .WRITE_DATA(WRITE_DATA), .READ_DATA(READ_DATA)
`ifdef REGMAP_ARB_STATS_EN
    , .STAT_CNT0(STAT_CNT0), .STAT_CNT1(STAT_CNT1)
`endif
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Two-register slave model, read data combinational from ADDR.
  logic [1:0] mem [2];
  assign READ_DATA = (ADDR < 3'd2) ? mem[ADDR[0]] : 2'b00;
  always @(posedge CLK) if (WRITE && ADDR < 3'd2) mem[ADDR[0]] <= WRITE_DATA;

  typedef struct { int cyc; logic wr; logic rd; logic [2:0] addr; logic [1:0] wd; } st_t;
  typedef struct { int cyc; int who; logic [1:0] rd; logic err; } ak_t;
  st_t st_q[$];
  ak_t ak_q[$];
  int tests = 0;
  int fails = 0;

  task automatic monitor_step();
    st_t se;
    ak_t ae;
    logic ok;
    @(negedge CLK);
    if (WRITE || READ) begin
      tests++;
      if (st_q.size() == 0) begin
        fails++;
        $display("FAIL strobe_unexpected cyc=%0d got W=%b R=%b addr=%0d, required no strobe", cyc, WRITE, READ, ADDR);
      end else begin
        se = st_q.pop_front();
        ok = (cyc == se.cyc) && (WRITE == se.wr) && (READ == se.rd) && (ADDR == se.addr) &&
             (!se.wr || WRITE_DATA == se.wd);
        if (!ok) begin
          fails++;
          $display("FAIL strobe cyc=%0d W=%b R=%b addr=%0d wd=%0d, required cyc=%0d W=%b R=%b addr=%0d wd=%0d",
                   cyc, WRITE, READ, ADDR, WRITE_DATA, se.cyc, se.wr, se.rd, se.addr, se.wd);
        end
      end
    end
    if (ACK0 || ACK1) begin
      tests++;
      if (ak_q.size() == 0) begin
        fails++;
        $display("FAIL ack_unexpected cyc=%0d got ACK0=%b ACK1=%b, required no ACK", cyc, ACK0, ACK1);
      end else begin
        ae = ak_q.pop_front();
        if (ae.who == 0)
          ok = ACK0 && !ACK1 && RDATA0 == ae.rd && ERR0 == ae.err && RDATA1 == 2'b00 && !ERR1;
        else
          ok = ACK1 && !ACK0 && RDATA1 == ae.rd && ERR1 == ae.err && RDATA0 == 2'b00 && !ERR0;
        ok = ok && (cyc == ae.cyc);
        if (!ok) begin
          fails++;
          $display("FAIL ack cyc=%0d ACK=%b%b RD0=%0d RD1=%0d ERR=%b%b, required cyc=%0d who=%0d rd=%0d err=%b",
                   cyc, ACK1, ACK0, RDATA0, RDATA1, ERR1, ERR0, ae.cyc, ae.who, ae.rd, ae.err);
        end
      end
    end
  endtask

  task automatic check_drain(input string name);
    tests++;
    if (st_q.size() != 0 || ak_q.size() != 0) begin
      fails++;
      $display("FAIL %s pending strobes=%0d acks=%0d, required 0 and 0", name, st_q.size(), ak_q.size());
      st_q.delete();
      ak_q.delete();
    end
  endtask

  task automatic check_zero(input string name);
    logic [14:0] v;
    v = {ACK0, ACK1, ERR0, ERR1, WRITE, READ, RDATA0, RDATA1, ADDR, WRITE_DATA};
    tests++;
    if (v != 15'd0) begin
      fails++;
      $display("FAIL %s outputs=%h, required 0", name, v);
    end
  endtask

  task automatic set_req(input int who, input logic we, input logic [2:0] a, input logic [1:0] wd);
    if (who == 0) begin REQ0 = 1'b1; WE0 = we; ADDR0 = a; WDATA0 = wd; end
    else          begin REQ1 = 1'b1; WE1 = we; ADDR1 = a; WDATA1 = wd; end
  endtask

  task automatic access(input string name, input int who, input logic we, input logic [2:0] a,
                        input logic [1:0] wd, input logic [1:0] exp_rd, input logic exp_err);
    int n;
    @(posedge CLK); #1;
    n = cyc;
    set_req(who, we, a, wd);
    if (!exp_err) st_q.push_back('{n + 1, we, !we, a, wd});
    ak_q.push_back('{n + 2, who, exp_rd, exp_err});
    repeat (3) @(posedge CLK);
    #1;
    REQ0 = 1'b0;
    REQ1 = 1'b0;
    check_drain(name);
  endtask

  task automatic do_reset();
    @(posedge CLK); #1;
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  initial begin
    int n;
    fork
      forever monitor_step();
    join_none

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_zero("reset_state");
    @(posedge CLK); #1;
    RST = 1'b0;

    access("wr0_addr0", 0, 1'b1, 3'd0, 2'b10, 2'b00, 1'b0);
    access("wr1_addr1", 1, 1'b1, 3'd1, 2'b01, 2'b00, 1'b0);
    access("rd1_addr1", 1, 1'b0, 3'd1, 2'b00, 2'b01, 1'b0);
    access("rd0_addr0", 0, 1'b0, 3'd0, 2'b00, 2'b10, 1'b0);

    // Contention from reset: grants 0,1,0,1 with ACKs three cycles apart.
    do_reset();
    @(posedge CLK); #1;
    n = cyc;
    set_req(0, 1'b0, 3'd0, 2'b00);
    set_req(1, 1'b0, 3'd1, 2'b00);
    for (int i = 0; i < 4; i++) begin
      st_q.push_back('{n + 1 + 3 * i, 1'b0, 1'b1, (i % 2 == 0) ? 3'd0 : 3'd1, 2'b00});
      ak_q.push_back('{n + 2 + 3 * i, i % 2, (i % 2 == 0) ? 2'b10 : 2'b01, 1'b0});
    end
    repeat (12) @(posedge CLK);
    #1;
    REQ0 = 1'b0;
    REQ1 = 1'b0;
    check_drain("contention");

    access("oor1_addr2", 1, 1'b0, 3'd2, 2'b00, 2'b00, 1'b1);
    access("oor0_addr5", 0, 1'b1, 3'd5, 2'b11, 2'b00, 1'b1);

    // Reset during ISSUE aborts the access; last-served was 0, reset must restore tie to 0.
    @(posedge CLK); #1;
    n = cyc;
    set_req(1, 1'b0, 3'd1, 2'b00);
    st_q.push_back('{n + 1, 1'b0, 1'b1, 3'd1, 2'b00});
    @(posedge CLK); #1;
    RST = 1'b1;
    REQ1 = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    check_zero("rst_abort");
    @(posedge CLK); #1;
    RST = 1'b0;
    check_drain("rst_abort_queue");

    @(posedge CLK); #1;
    n = cyc;
    set_req(0, 1'b0, 3'd0, 2'b00);
    set_req(1, 1'b0, 3'd1, 2'b00);
    st_q.push_back('{n + 1, 1'b0, 1'b1, 3'd0, 2'b00});
    ak_q.push_back('{n + 2, 0, 2'b10, 1'b0});
    st_q.push_back('{n + 4, 1'b0, 1'b1, 3'd1, 2'b00});
    ak_q.push_back('{n + 5, 1, 2'b01, 1'b0});
    repeat (3) @(posedge CLK);
    #1;
    REQ0 = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    REQ1 = 1'b0;
    check_drain("tie_after_reset");

`ifdef REGMAP_ARB_STATS_EN
    do_reset();
    for (int i = 0; i < 300; i++) access("stats_rd0", 0, 1'b0, 3'd0, 2'b00, 2'b10, 1'b0);
    tests++;
    if (STAT_CNT0 != 8'd255 || STAT_CNT1 != 8'd0) begin
      fails++;
      $display("FAIL stat_sat cnt0=%0d cnt1=%0d, required 255 and 0", STAT_CNT0, STAT_CNT1);
    end
`endif

    repeat (3) @(posedge CLK);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
